input_conditioner: RTL and testbench

Front-end for the code-lock system. It takes the raw slide-switch and push-button levels, synchronizes and debounces them, and turns them into one-cycle event pulses: which switch changed and to what value, and which button was pressed. These pulses feed the lock state machine's code-change and button-change inputs. Simultaneous events are queued and released one per cycle, so the consumer never sees two events in the same cycle.

---
 rtl/input_conditioner_pkg.sv | 17 +
 rtl/tick_gen.sv | 28 ++
 rtl/input_conditioner.sv | 198 +++++++++++++++++++
 tb/tb_input_conditioner.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared widths, button codes and FSM encoding
// for the code-lock input conditioner.
package input_conditioner_pkg;

    localparam int SW_W  = 10;
    localparam int BTN_W = 3;

    localparam logic [1:0] BTN_ADMIN     = 2'd0;
    localparam logic [1:0] BTN_OK        = 2'd1;
    localparam logic [1:0] BTN_BACKSPACE = 2'd2;

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every
// TICK_CYCLES clocks, asserted on the wrap count.
module tick_gen #(
    parameter int TICK_CYCLES = 100000
) (
    input  logic CLK,
    input  logic RESET,
    output logic tick
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Sync, debounce and event queue for switches and
// buttons; emits at most one event pulse per cycle.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int TICK_CYCLES    = 100000,
    parameter int STABLE_SAMPLES = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [9:0]       SW,
    input  logic [2:0]       BTN,
    output logic [9:0]       SW_Stable,
    output logic [2:0]       BTN_Stable,
    output logic             Code_Change_Flag,
    output logic [3:0]       Code_Bit_Index,
    output logic             Code_Bit_Value,
    output logic             BTN_Change_Flag,
    output logic [1:0]       Which_BTN_Change,
    output logic             Busy
);

    localparam int SS = STABLE_SAMPLES;
    localparam logic [1:0] PRIME_LAST = 2'(SS - 1);

    logic tick;

    tick_gen #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_tick_gen (
        .CLK  (CLK),
        .RESET(RESET),
        .tick (tick)
    );

    logic [SW_W-1:0]  sw_s1, sw_s2;
    logic [BTN_W-1:0] btn_s1, btn_s2;

    logic [SW_W-1:0][SS-1:0]  sw_hist, sw_hist_nx;
    logic [BTN_W-1:0][SS-1:0] btn_hist, btn_hist_nx;

    logic [SW_W-1:0]  sw_stb, sw_stb_nx;
    logic [BTN_W-1:0] btn_stb, btn_stb_nx;
    logic [SW_W-1:0]  sw_set, sw_cand, sw_pend, sw_pend_nx;
    logic [BTN_W-1:0] btn_set, btn_cand, btn_pend, btn_pend_nx;

    state_t     state, state_nx;
    logic [1:0] prime_cnt, prime_cnt_nx;

    logic       code_flag_nx, btn_flag_nx;
    logic [3:0] code_idx_nx;
    logic       code_val_nx;
    logic [1:0] btn_code_nx;
    logic       hit;

    function automatic logic settled(input logic [SS-1:0] h);
        return (&h) | ~(|h);
    endfunction

    function automatic logic [1:0] btn_code(input int j);
        if (j == 0) return BTN_ADMIN;
        else if (j == 1) return BTN_OK;
        else return BTN_BACKSPACE;
    endfunction

    assign SW_Stable  = sw_stb;
    assign BTN_Stable = btn_stb;
    assign Busy = (state == PRIME) | (|sw_pend) | (|btn_pend)
                | Code_Change_Flag | BTN_Change_Flag;

    // Sampling, priming and acceptance
    always_comb begin
        state_nx     = state;
        prime_cnt_nx = prime_cnt;
        sw_hist_nx   = sw_hist;
        btn_hist_nx  = btn_hist;
        sw_stb_nx    = sw_stb;
        btn_stb_nx   = btn_stb;
        sw_set       = '0;
        btn_set      = '0;
        if (tick) begin
            for (int i = 0; i < SW_W; i++)
                sw_hist_nx[i] = {sw_hist[i][SS-2:0], sw_s2[i]};
            for (int j = 0; j < BTN_W; j++)
                btn_hist_nx[j] = {btn_hist[j][SS-2:0], btn_s2[j]};
        end
        unique case (state)
            PRIME: begin
                if (tick) begin
                    if (prime_cnt == PRIME_LAST) begin
                        state_nx   = RUN;
                        sw_stb_nx  = sw_s2;
                        btn_stb_nx = btn_s2;
                    end else begin
                        prime_cnt_nx = prime_cnt + 2'd1;
                    end
                end
            end
            RUN: begin
                if (tick) begin
                    for (int i = 0; i < SW_W; i++) begin
                        if (settled(sw_hist_nx[i]) &&
                            sw_hist_nx[i][0] != sw_stb[i]) begin
                            sw_stb_nx[i] = sw_hist_nx[i][0];
                            sw_set[i]    = 1'b1;
                        end
                    end
                    // Releases update the level but queue nothing
                    for (int j = 0; j < BTN_W; j++) begin
                        if (settled(btn_hist_nx[j]) &&
                            btn_hist_nx[j][0] != btn_stb[j]) begin
                            btn_stb_nx[j] = btn_hist_nx[j][0];
                            btn_set[j]    = btn_hist_nx[j][0];
                        end
                    end
                end
            end
        endcase
    end

    // Drain: newly accepted events may leave in the accepting cycle
    always_comb begin
        sw_cand      = sw_pend | sw_set;
        btn_cand     = btn_pend | btn_set;
        sw_pend_nx   = sw_cand;
        btn_pend_nx  = btn_cand;
        code_flag_nx = 1'b0;
        btn_flag_nx  = 1'b0;
        code_idx_nx  = Code_Bit_Index;
        code_val_nx  = Code_Bit_Value;
        btn_code_nx  = Which_BTN_Change;
        hit          = 1'b0;
        for (int j = 0; j < BTN_W; j++) begin
            if (!hit && btn_cand[j]) begin
                hit            = 1'b1;
                btn_flag_nx    = 1'b1;
                btn_code_nx    = btn_code(j);
                btn_pend_nx[j] = 1'b0;
            end
        end
        for (int i = 0; i < SW_W; i++) begin
            if (!hit && sw_cand[i]) begin
                hit           = 1'b1;
                code_flag_nx  = 1'b1;
                code_idx_nx   = 4'(i);
                code_val_nx   = sw_stb_nx[i];
                sw_pend_nx[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= PRIME;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sw_s1            <= '0;
            sw_s2            <= '0;
            btn_s1           <= '0;
            btn_s2           <= '0;
            sw_hist          <= '0;
            btn_hist         <= '0;
            sw_stb           <= '0;
            btn_stb          <= '0;
            sw_pend          <= '0;
            btn_pend         <= '0;
            prime_cnt        <= '0;
            Code_Change_Flag <= 1'b0;
            Code_Bit_Index   <= '0;
            Code_Bit_Value   <= 1'b0;
            BTN_Change_Flag  <= 1'b0;
            Which_BTN_Change <= '0;
        end else begin
            sw_s1            <= SW;
            sw_s2            <= sw_s1;
            btn_s1           <= BTN;
            btn_s2           <= btn_s1;
            sw_hist          <= sw_hist_nx;
            btn_hist         <= btn_hist_nx;
            sw_stb           <= sw_stb_nx;
            btn_stb          <= btn_stb_nx;
            sw_pend          <= sw_pend_nx;
            btn_pend         <= btn_pend_nx;
            prime_cnt        <= prime_cnt_nx;
            Code_Change_Flag <= code_flag_nx;
            Code_Bit_Index   <= code_idx_nx;
            Code_Bit_Value   <= code_val_nx;
            BTN_Change_Flag  <= btn_flag_nx;
            Which_BTN_Change <= btn_code_nx;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with
// TICK_CYCLES=16 and STABLE_SAMPLES=3.
module tb_input_conditioner;

    localparam int TC = 16;
    localparam int SS = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [9:0] SW = '0;
    logic [2:0] BTN = '0;
    logic [9:0] SW_Stable;
    logic [2:0] BTN_Stable;
    logic       Code_Change_Flag;
    logic [3:0] Code_Bit_Index;
    logic       Code_Bit_Value;
    logic       BTN_Change_Flag;
    logic [1:0] Which_BTN_Change;
    logic       Busy;

    input_conditioner #(
        .TICK_CYCLES(TC),
        .STABLE_SAMPLES(SS)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .SW              (SW),
        .BTN             (BTN),
        .SW_Stable       (SW_Stable),
        .BTN_Stable      (BTN_Stable),
        .Code_Change_Flag(Code_Change_Flag),
        .Code_Bit_Index  (Code_Bit_Index),
        .Code_Bit_Value  (Code_Bit_Value),
        .BTN_Change_Flag (BTN_Change_Flag),
        .Which_BTN_Change(Which_BTN_Change),
        .Busy            (Busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    int rel0 = 0;
    int n_cmp = 0;
    int n_bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        bit btn;
        int idx;
        int val;
        int at;
    } ev_t;

    ev_t evq[$];

    always @(negedge CLK) begin
        if (BTN_Change_Flag)
            evq.push_back('{1'b1, int'(Which_BTN_Change), 0, cyc - rel0});
        if (Code_Change_Flag)
            evq.push_back('{1'b0, int'(Code_Bit_Index),
                            int'(Code_Bit_Value), cyc - rel0});
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ev_t first_ev();
        ev_t e;
        e = '{1'b0, -1, -1, -1};
        if (evq.size() > 0) e = evq[0];
        return e;
    endfunction

    task automatic wait_ev(input int budget, output int lat);
        lat = -1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge CLK);
            if (Code_Change_Flag || BTN_Change_Flag) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            if (!Busy) break;
            n++;
            @(negedge CLK);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_sw"}, 32'(SW_Stable), 0);
        chk({tag, "_btn"}, 32'(BTN_Stable), 0);
        chk({tag, "_flags"},
            32'({Code_Change_Flag, BTN_Change_Flag}), 0);
        chk({tag, "_idxval"},
            32'({Code_Bit_Index, Code_Bit_Value, Which_BTN_Change}), 0);
        chk({tag, "_busy"}, 32'(Busy), 1);
    endtask

    initial begin
        int   lat;
        int   nb;
        int   settle;
        ev_t  e;

        // 1: priming with SW held at 10'h205
        SW = 10'h205;
        repeat (3) @(negedge CLK);
        chk_reset_outs("t1_rst");
        RESET = 1'b1;
        rel0 = cyc;
        count_busy(nb);
        chk("t1_busy_cycles", 32'(nb), 48);
        chk("t1_sw_stable", 32'(SW_Stable), 32'h205);
        chk("t1_no_events", 32'(evq.size()), 0);

        // 2: clean toggle of SW[4]
        repeat (7) @(negedge CLK);
        evq.delete();
        SW[4] = 1'b1;
        wait_ev(100, lat);
        chk("t2_lat_in_bounds", 32'(lat >= 35 && lat <= 63), 1);
        repeat (40) @(negedge CLK);
        e = first_ev();
        chk("t2_count", 32'(evq.size()), 1);
        chk("t2_ev", 32'({e.btn, 4'(e.idx), 1'(e.val)}), 32'({1'b0, 4'd4, 1'b1}));

        // 3: SW[7] bounces every 10 cycles, sample points 5 cycles from edges
        while (((cyc - rel0 + 1) % TC) != 10) @(negedge CLK);
        evq.delete();
        for (int k = 0; k < 6; k++) begin
            SW[7] = ~SW[7];
            repeat (10) @(negedge CLK);
        end
        SW[7] = 1'b1;
        settle = cyc - rel0;
        repeat (150) @(negedge CLK);
        e = first_ev();
        chk("t3_count", 32'(evq.size()), 1);
        chk("t3_ev", 32'({e.btn, 4'(e.idx), 1'(e.val)}), 32'({1'b0, 4'd7, 1'b1}));
        chk("t3_after_settle", 32'(e.at > settle), 1);
        chk("t3_sw_stable", 32'(SW_Stable), 32'h295);

        // 4: BTN[1] press with SW[0] and SW[9] falling together
        evq.delete();
        BTN[1] = 1'b1;
        SW[0] = 1'b0;
        SW[9] = 1'b0;
        wait_ev(100, lat);
        chk("t4_first_btn", 32'({BTN_Change_Flag, Code_Change_Flag}), 32'b10);
        chk("t4_btn_code", 32'(Which_BTN_Change), 1);
        @(negedge CLK);
        chk("t4_second", 32'({BTN_Change_Flag, Code_Change_Flag,
            Code_Bit_Index, Code_Bit_Value}), 32'({2'b01, 4'd0, 1'b0}));
        @(negedge CLK);
        chk("t4_third", 32'({BTN_Change_Flag, Code_Change_Flag,
            Code_Bit_Index, Code_Bit_Value}), 32'({2'b01, 4'd9, 1'b0}));
        @(negedge CLK);
        chk("t4_busy_low", 32'({Busy, Code_Change_Flag, BTN_Change_Flag}), 0);
        chk("t4_stables", 32'({BTN_Stable, SW_Stable}), 32'({3'b010, 10'h094}));

        // 5: releases are silent; BTN[2] press reports code 2
        evq.delete();
        BTN[1] = 1'b0;
        repeat (80) @(negedge CLK);
        chk("t5_rel1_silent", 32'(evq.size()), 0);
        chk("t5_rel1_level", 32'(BTN_Stable), 0);
        BTN[2] = 1'b1;
        wait_ev(100, lat);
        chk("t5_press", 32'({BTN_Change_Flag, Which_BTN_Change}), 32'({1'b1, 2'd2}));
        repeat (20) @(negedge CLK);
        chk("t5_pressed_level", 32'(BTN_Stable), 32'b100);
        BTN[2] = 1'b0;
        repeat (80) @(negedge CLK);
        chk("t5_total_events", 32'(evq.size()), 1);
        chk("t5_released_level", 32'(BTN_Stable), 0);

        // 6: reset lands while two events are still queued
        evq.delete();
        SW[3:1] = 3'b111;
        wait_ev(100, lat);
        chk("t6_first", 32'({Code_Change_Flag, Code_Bit_Index, Code_Bit_Value}),
            32'({1'b1, 4'd1, 1'b1}));
        #1 RESET = 1'b0;
        #1 chk_reset_outs("t6_rst");
        repeat (5) @(negedge CLK);
        chk_reset_outs("t6_rst_hold");
        chk("t6_dropped", 32'(evq.size()), 1);
        RESET = 1'b1;
        count_busy(nb);
        chk("t6_reprime_busy", 32'(nb), 48);
        chk("t6_sw_stable", 32'(SW_Stable), 32'h09E);
        repeat (40) @(negedge CLK);
        chk("t6_no_more", 32'(evq.size()), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
